// File: rtl/mii_rx_ctrl.sv
// Receive-frame controller: turns the byte stream from the mii assembler into
// Ethernet frames, checking preamble/SFD, capturing the header, filtering on the
// destination address and forwarding payload+FCS bytes with frame status pulses.
module mii_rx_ctrl #(
  parameter logic [47:0] MAC_ADDR = 48'h54_ff_01_21_23_24,
  parameter bit          PROMISC  = 1'b0,
  parameter logic [7:0]  PRE_BYTE = 8'hAA,
  parameter logic [7:0]  SFD_BYTE = 8'hBA,
  parameter int unsigned MIN_PRE  = 7,
  parameter int unsigned MIN_LEN  = 4
) (
  input  logic        i_mii_clk,
  input  logic        i_reset,
  input  logic        i_dv,
  input  logic        i_rdy,
  input  logic [7:0]  i_q,
  output logic        o_frame_start,
  output logic [47:0] o_dst,
  output logic [47:0] o_src,
  output logic [15:0] o_etype,
  output logic        o_addr_match,
  output logic [7:0]  o_dout,
  output logic        o_dout_valid,
  output logic [15:0] o_frame_len,
  output logic        o_frame_end,
  output logic        o_frame_ok,
  output logic        o_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DST  = 3'd2;
  localparam logic [2:0] S_SRC  = 3'd3;
  localparam logic [2:0] S_TYPE = 3'd4;
  localparam logic [2:0] S_PAY  = 3'd5;
  localparam logic [2:0] S_DROP = 3'd6;

  // The preamble counter saturates at 15, so larger minimums clamp there.
  localparam logic [3:0]  MIN_PRE_C = 4'((MIN_PRE > 15) ? 15 : MIN_PRE);
  localparam logic [15:0] MIN_LEN_C = 16'((MIN_LEN > 16'hFFFF) ? 16'hFFFF : MIN_LEN);

  logic [2:0]  r_state;
  logic        r_rdy_q;
  logic [3:0]  r_pre_cnt;
  logic [2:0]  r_fcnt;
  logic        r_frame_start;
  logic [47:0] r_dst;
  logic [47:0] r_src;
  logic [15:0] r_etype;
  logic        r_addr_match;
  logic [7:0]  r_dout;
  logic        r_dout_valid;
  logic [15:0] r_frame_len;
  logic        r_frame_end;
  logic        r_frame_ok;
  logic        r_err;

  logic        w_acc;
  logic [47:0] w_dst_shift;
  logic        w_dst_match;

  // Byte acceptance strobe and the address filter on the next destination value.
  always_comb begin
    w_acc       = i_rdy & ~r_rdy_q & i_dv;
    w_dst_shift = {r_dst[39:0], i_q};
    w_dst_match = (w_dst_shift == MAC_ADDR) || (w_dst_shift == 48'hFFFF_FFFF_FFFF);
  end

  // Frame sequencing, header capture and registered outputs.
  always_ff @(posedge i_mii_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_rdy_q       <= 1'b0;
      r_pre_cnt     <= 4'd0;
      r_fcnt        <= 3'd0;
      r_frame_start <= 1'b0;
      r_dst         <= 48'd0;
      r_src         <= 48'd0;
      r_etype       <= 16'd0;
      r_addr_match  <= 1'b0;
      r_dout        <= 8'd0;
      r_dout_valid  <= 1'b0;
      r_frame_len   <= 16'd0;
      r_frame_end   <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdy_q       <= i_rdy;
      r_frame_start <= 1'b0;
      r_dout_valid  <= 1'b0;
      r_frame_end   <= 1'b0;
      r_err         <= 1'b0;
      if (!i_dv) begin
        // dv low ends any frame; a coincident byte strobe is discarded.
        if (r_state != S_IDLE) begin
          r_state <= S_IDLE;
          unique case (r_state)
            S_PAY: begin
              r_frame_end <= 1'b1;
              r_frame_ok  <= (r_frame_len >= MIN_LEN_C);
            end
            S_DST, S_SRC, S_TYPE: r_err <= 1'b1;
            default: ;
          endcase
        end
      end else if (w_acc) begin
        unique case (r_state)
          S_IDLE: begin
            if (i_q == PRE_BYTE) begin
              r_state   <= S_PRE;
              r_pre_cnt <= 4'd1;
            end else begin
              r_state <= S_DROP;
              r_err   <= 1'b1;
            end
          end
          S_PRE: begin
            if (i_q == PRE_BYTE) begin
              if (r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
            end else if ((i_q == SFD_BYTE) && (r_pre_cnt >= MIN_PRE_C)) begin
              r_state       <= S_DST;
              r_fcnt        <= 3'd0;
              r_frame_start <= 1'b1;
              r_dst         <= 48'd0;
              r_src         <= 48'd0;
              r_etype       <= 16'd0;
              r_frame_len   <= 16'd0;
              r_addr_match  <= 1'b0;
            end else begin
              r_state <= S_DROP;
              r_err   <= 1'b1;
            end
          end
          S_DST: begin
            r_dst        <= w_dst_shift;
            r_addr_match <= w_dst_match;
            if (r_fcnt == 3'd5) begin
              r_state <= S_SRC;
              r_fcnt  <= 3'd0;
            end else begin
              r_fcnt <= r_fcnt + 3'd1;
            end
          end
          S_SRC: begin
            r_src <= {r_src[39:0], i_q};
            if (r_fcnt == 3'd5) begin
              r_state <= S_TYPE;
              r_fcnt  <= 3'd0;
            end else begin
              r_fcnt <= r_fcnt + 3'd1;
            end
          end
          S_TYPE: begin
            r_etype <= {r_etype[7:0], i_q};
            if (r_fcnt == 3'd1) begin
              r_fcnt  <= 3'd0;
              // Filtered frames are dropped without an error indication.
              r_state <= (r_addr_match | PROMISC) ? S_PAY : S_DROP;
            end else begin
              r_fcnt <= r_fcnt + 3'd1;
            end
          end
          S_PAY: begin
            r_dout       <= i_q;
            r_dout_valid <= 1'b1;
            if (r_frame_len != 16'hFFFF) r_frame_len <= r_frame_len + 16'd1;
          end
          S_DROP: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_frame_start = r_frame_start;
  assign o_dst         = r_dst;
  assign o_src         = r_src;
  assign o_etype       = r_etype;
  assign o_addr_match  = r_addr_match;
  assign o_dout        = r_dout;
  assign o_dout_valid  = r_dout_valid;
  assign o_frame_len   = r_frame_len;
  assign o_frame_end   = r_frame_end;
  assign o_frame_ok    = r_frame_ok;
  assign o_err         = r_err;

endmodule

// File: tb/tb_mii_rx_ctrl.sv
// Directed bench for mii_rx_ctrl: a filtering instance and a promiscuous one
// share the same stimulus; negedge monitors count pulses and capture payload.
module tb_mii_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic        rdy;
  logic [7:0]  q;

  logic        fs, am, dvl, fe, ok, er;
  logic [47:0] dst, src;
  logic [15:0] et, flen;
  logic [7:0]  dout;

  logic        fs_p, am_p, dvl_p, fe_p, ok_p, er_p;
  logic [47:0] dst_p, src_p;
  logic [15:0] et_p, flen_p;
  logic [7:0]  dout_p;

  always #5 clk = ~clk;

  mii_rx_ctrl dut (
    .i_mii_clk(clk), .i_reset(rst), .i_dv(dv), .i_rdy(rdy), .i_q(q),
    .o_frame_start(fs), .o_dst(dst), .o_src(src), .o_etype(et), .o_addr_match(am),
    .o_dout(dout), .o_dout_valid(dvl), .o_frame_len(flen), .o_frame_end(fe),
    .o_frame_ok(ok), .o_err(er)
  );

  mii_rx_ctrl #(.PROMISC(1'b1)) dut_p (
    .i_mii_clk(clk), .i_reset(rst), .i_dv(dv), .i_rdy(rdy), .i_q(q),
    .o_frame_start(fs_p), .o_dst(dst_p), .o_src(src_p), .o_etype(et_p),
    .o_addr_match(am_p), .o_dout(dout_p), .o_dout_valid(dvl_p), .o_frame_len(flen_p),
    .o_frame_end(fe_p), .o_frame_ok(ok_p), .o_err(er_p)
  );

  // Pulse monitors (outputs are sampled mid-cycle).
  int          n_fs = 0, n_fe = 0, n_err = 0, n_dv = 0, n_dv_p = 0, n_fe_p = 0;
  logic [7:0]  obytes [0:255];
  logic        last_ok = 1'b0;
  logic [15:0] last_len = 16'd0;

  always @(negedge clk) begin
    if (fs) n_fs <= n_fs + 1;
    if (er) n_err <= n_err + 1;
    if (dvl) begin
      obytes[n_dv % 256] <= dout;
      n_dv <= n_dv + 1;
    end
    if (fe) begin
      n_fe     <= n_fe + 1;
      last_ok  <= ok;
      last_len <= flen;
    end
    if (dvl_p) n_dv_p <= n_dv_p + 1;
    if (fe_p)  n_fe_p <= n_fe_p + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] frm [$];

  task automatic build(input int npre, input logic [47:0] d, input logic [47:0] s,
                       input logic [15:0] t, input int npay);
    frm.delete();
    for (int i = 0; i < npre; i++) frm.push_back(8'hAA);
    frm.push_back(8'hBA);
    for (int i = 0; i < 6; i++) frm.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(s[47-8*i -: 8]);
    frm.push_back(t[15:8]);
    frm.push_back(t[7:0]);
    for (int i = 0; i < npay; i++) frm.push_back(8'(8'h40 + i));
  endtask

  task automatic send_byte(input logic [7:0] b);
    q   = b;
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_frame();
    dv = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Sends bytes [first, n) of the built frame, then drops dv.
  task automatic send(input int first, input int n);
    dv = 1'b1;
    for (int i = first; i < n; i++) send_byte(frm[i]);
    end_frame();
  endtask

  task automatic held_aa();
    dv  = 1'b1;
    q   = 8'hAA;
    rdy = 1'b1;
    repeat (4) @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [47:0] MYMAC = 48'h54ff01212324;
  localparam logic [47:0] SRCA  = 48'h123456789abc;
  localparam logic [47:0] OTHER = 48'h112233445566;
  localparam logic [47:0] BCAST = 48'hffffffffffff;

  int b_fs, b_fe, b_err, b_dv, b_dvp, b_fep, mism;

  task automatic snap();
    b_fs = n_fs; b_fe = n_fe; b_err = n_err; b_dv = n_dv; b_dvp = n_dv_p; b_fep = n_fe_p;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dv = 1'b0; rdy = 1'b0; q = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_dst",  64'(dst), 64'd0);
    chk("reset_src",  64'(src), 64'd0);
    chk("reset_misc", 64'({et, flen, dout, fs, am, dvl, fe, ok, er}), 64'd0);

    // Nominal frame.
    snap();
    build(7, MYMAC, SRCA, 16'h1234, 36);
    send(0, frm.size());
    chk("nom_fs",    64'(n_fs - b_fs), 64'd1);
    chk("nom_dst",   64'(dst), 64'(MYMAC));
    chk("nom_src",   64'(src), 64'(SRCA));
    chk("nom_etype", 64'(et), 64'h1234);
    chk("nom_match", 64'(am), 64'd1);
    chk("nom_ndv",   64'(n_dv - b_dv), 64'd36);
    mism = 0;
    for (int k = 0; k < 36; k++)
      if (obytes[(b_dv + k) % 256] !== 8'(8'h40 + k)) mism++;
    chk("nom_order", 64'(mism), 64'd0);
    chk("nom_fe",    64'(n_fe - b_fe), 64'd1);
    chk("nom_ok",    64'(last_ok), 64'd1);
    chk("nom_len",   64'(last_len), 64'd36);
    chk("nom_err",   64'(n_err - b_err), 64'd0);

    // Non-matching destination: filtered vs promiscuous.
    snap();
    build(7, OTHER, SRCA, 16'h0800, 36);
    send(0, frm.size());
    chk("flt_dst",   64'(dst), 64'(OTHER));
    chk("flt_etype", 64'(et), 64'h0800);
    chk("flt_match", 64'(am), 64'd0);
    chk("flt_ndv",   64'(n_dv - b_dv), 64'd0);
    chk("flt_fe",    64'(n_fe - b_fe), 64'd0);
    chk("flt_err",   64'(n_err - b_err), 64'd0);
    chk("prm_ndv",   64'(n_dv_p - b_dvp), 64'd36);
    chk("prm_fe",    64'(n_fe_p - b_fep), 64'd1);

    // Broadcast.
    snap();
    build(7, BCAST, SRCA, 16'h1234, 36);
    send(0, frm.size());
    chk("bc_match", 64'(am), 64'd1);
    chk("bc_ndv",   64'(n_dv - b_dv), 64'd36);

    // Short preamble, then a good frame.
    snap();
    build(5, MYMAC, SRCA, 16'h1234, 8);
    send(0, frm.size());
    chk("spre_err", 64'(n_err - b_err), 64'd1);
    chk("spre_fs",  64'(n_fs - b_fs), 64'd0);
    chk("spre_ndv", 64'(n_dv - b_dv), 64'd0);
    chk("spre_dst", 64'(dst), 64'(BCAST));
    snap();
    build(7, MYMAC, SRCA, 16'h1234, 36);
    send(0, frm.size());
    chk("after_fs",  64'(n_fs - b_fs), 64'd1);
    chk("after_ndv", 64'(n_dv - b_dv), 64'd36);

    // Runt header: dv dropped after 3 source bytes.
    snap();
    send(0, 8 + 6 + 3);
    chk("runt_err", 64'(n_err - b_err), 64'd1);
    chk("runt_fe",  64'(n_fe - b_fe), 64'd0);

    // Two payload bytes only.
    snap();
    build(7, MYMAC, SRCA, 16'h1234, 2);
    send(0, frm.size());
    chk("short_fe",  64'(n_fe - b_fe), 64'd1);
    chk("short_ok",  64'(last_ok), 64'd0);
    chk("short_len", 64'(flen), 64'd2);
    chk("short_err", 64'(n_err - b_err), 64'd0);

    // Reset in the middle of the payload.
    build(7, MYMAC, SRCA, 16'h1234, 36);
    dv = 1'b1;
    for (int i = 0; i < 27; i++) send_byte(frm[i]);
    rst = 1'b1;
    dv  = 1'b0;
    @(negedge clk);
    chk("mrst_fields", 64'({dst[15:0], src[15:0], et, flen}), 64'd0);
    chk("mrst_misc",   64'({dout, fs, am, dvl, fe, ok, er}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rel_dst", 64'(dst), 64'd0);

    // A held rdy counts once: held AA + 5 AA gives only 6 preamble bytes.
    snap();
    held_aa();
    for (int i = 0; i < 5; i++) send_byte(8'hAA);
    send_byte(8'hBA);
    end_frame();
    chk("hold_err", 64'(n_err - b_err), 64'd1);
    chk("hold_fs",  64'(n_fs - b_fs), 64'd0);

    // Good frame whose first preamble byte is held.
    snap();
    held_aa();
    send(1, frm.size());
    chk("hold2_fs",  64'(n_fs - b_fs), 64'd1);
    chk("hold2_ndv", 64'(n_dv - b_dv), 64'd36);
    chk("hold2_len", 64'(last_len), 64'd36);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mii_rx_ctrl.md
# mii_rx_ctrl

Receive-frame controller that sits directly behind the `mii` nibble-to-byte assembler and sequences its byte stream into Ethernet frames. It edge-detects the `mii` byte strobe and validates preamble and SFD. It captures the destination, source and type fields and applies destination-address filtering. It then forwards payload bytes (FCS included) to the downstream MAC logic with start, end and status pulses, all in the `mii_clk` domain.

## Interface
- `MAC_ADDR`, default 48'h54_ff_01_21_23_24: station address accepted by the filter.
- `PROMISC`, default 0: 1 = forward every frame regardless of address match.
- `PRE_BYTE`, default 8'hAA: preamble byte value as presented on `q`.
- `SFD_BYTE`, default 8'hBA: start-of-frame delimiter as presented on `q`.
- `MIN_PRE`, default 7: minimum preamble bytes required before the SFD.
- `MIN_LEN`, default 4: minimum payload+FCS byte count for `frame_ok`.
- `mii_clk` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `dv` in 1: receive data valid from the PHY; low = no frame in progress.
- `rdy` in 1: byte-ready level from `mii`.
- `q` in 8: assembled byte from `mii`, stable while `rdy`=1.
- `frame_start` out 1: one-cycle pulse when the SFD is accepted.
- `dst` out 48: destination address; first byte lands in [47:40].
- `src` out 48: source address; first byte lands in [47:40].
- `etype` out 16: type field; first byte lands in [15:8].
- `addr_match` out 1: `dst`==`MAC_ADDR` or `dst`==48'hFFFF_FFFF_FFFF; valid from the TYPE state onward.
- `dout` out 8: payload/FCS byte.
- `dout_valid` out 1: one-cycle qualifier for `dout`.
- `frame_len` out 16: payload+FCS bytes forwarded in the current frame.
- `frame_end` out 1: one-cycle pulse at the end of a forwarded frame.
- `frame_ok` out 1: status qualified by `frame_end`.
- `err` out 1: one-cycle pulse on a framing error.

## Operation
- Byte strobe: register `rdy_q`. A byte is accepted at the edge where `rdy`=1, `rdy_q`=0 and `dv`=1. Exactly one acceptance per `rdy` high period, whatever its length.
- States: IDLE, PRE, DST, SRC, TYPE, PAY, DROP. A 4-bit preamble counter saturates at 15. A 3-bit field byte counter indexes header fields.
- IDLE: byte==`PRE_BYTE` → PRE, pre_cnt=1. Any other byte → DROP plus `err`.
- PRE:
  - `PRE_BYTE` → pre_cnt+1.
  - `SFD_BYTE` with pre_cnt≥`MIN_PRE` → DST, `frame_start`, clear `dst`/`src`/`etype`/`frame_len`.
  - `SFD_BYTE` with pre_cnt<`MIN_PRE` → DROP plus `err`.
  - Any other byte → DROP plus `err`.
- DST / SRC: shift bytes in MSB-first, 6 bytes each, then advance. TYPE: 2 bytes.
- After the last TYPE byte, go to PAY if `addr_match`|`PROMISC`, else go to DROP silently.
- PAY: each accepted byte → `dout`=q, `dout_valid`=1, `frame_len`+1, saturating at 16'hFFFF.
- DROP: ignore bytes until `dv`=0.
- `dv`=0 in any non-IDLE state → IDLE on that edge. A coincident byte strobe is discarded, so `dv` low wins.
  - From PAY: `frame_end`=1, `frame_ok`=(`frame_len`≥`MIN_LEN`).
  - From DST/SRC/TYPE (runt header): `err`=1, no `frame_end`.
  - From PRE/DROP: silent.
- `dst`/`src`/`etype`/`frame_len` hold their values after the frame until the next `frame_start`.

## Timing
- Reset values: state IDLE; every output 0, including all 48/16-bit fields; `rdy_q`=0.
- Outputs are registered. They change at the acceptance edge and are visible in the following cycle.
- `dout`, `dout_valid`, `frame_start` and `err` have latency 1 cycle from the `rdy` rising edge sample.
- `frame_end` and `frame_ok` assert the cycle after `dv` is sampled low. `frame_len` is final on that same cycle.
- Pulses (`frame_start`, `dout_valid`, `frame_end`, `err`) last exactly one cycle.
- Bytes arrive no faster than every 2 `mii_clk` cycles; no back-pressure exists.
- `reset` mid-frame: immediate return to reset values. The first accepted byte after release is treated as IDLE input.

## Test plan
- Nominal frame, default parameters. Stimulus on `q`: 7×AA, BA, dst 54 FF 01 21 23 24, src 12 34 56 78 9A BC, type 12 34, 32 payload bytes, 4 FCS bytes, then `dv`=0.
  - Required: one `frame_start`; `dst`=48'h54ff01212324; `src`=48'h123456789abc; `etype`=16'h1234; `addr_match`=1.
  - Required: 36 `dout_valid` pulses with bytes in order; `frame_end` with `frame_ok`=1 and `frame_len`=36; no `err`.
- Same frame with dst 11 22 33 44 55 66 and `PROMISC`=0 → header captured, `addr_match`=0, no `dout_valid`, no `frame_end`, no `err`. With `PROMISC`=1 → 36 bytes forwarded.
- Broadcast dst FF×6 → `addr_match`=1, frame forwarded.
- Short preamble: 5×AA then BA → `err` pulse, no `frame_start`, nothing forwarded until `dv` cycles low. The next good frame is received normally.
- `dv` dropped after 3 src bytes → `err` pulse, no `frame_end`. Separately, 2 payload bytes then `dv`=0 → `frame_end`, `frame_ok`=0, `frame_len`=2.
- `reset` pulsed mid-payload, and `rdy` held high for 4 cycles → all outputs 0, state IDLE. A held `rdy` yields exactly one byte acceptance.
